// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared state type and counter sizing for the systolic array feed/drain blocks
package sys_array_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } feeder_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage data/valid shift register for one skewed lane
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]                 valid_q, valid_d;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    data_d[0]  = in_data;
    valid_d[0] = in_valid;
    for (int k = 1; k < DEPTH; k++) begin
      data_d[k]  = data_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// rtl/sys_array_feeder.sv - weight loader and diagonally skewed input feeder for the systolic array
// Optional vector counter output enabled by SYS_FEEDER_STATS_EN.
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_N    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] param_in,
  input  logic                          param_in_valid,
  output logic                          param_in_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] vec_in,
  input  logic                          vec_valid,
  input  logic                          vec_last,
  output logic                          vec_ready,
  output logic [ARRAY_N*DATA_WIDTH-1:0] param_data,
  output logic                          param_load,
  output logic [ARRAY_N*DATA_WIDTH-1:0] input_data,
  output logic [ARRAY_N-1:0]            row_valid,
  output logic                          done,
  output logic                          busy
`ifdef SYS_FEEDER_STATS_EN
  ,
  output logic [15:0]                   vec_count
`endif
);

  localparam int CNT_W = cnt_width(ARRAY_N);

  feeder_state_t                 state_q, state_d;
  logic [CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]              flush_cnt_q, flush_cnt_d;
  logic [ARRAY_N*DATA_WIDTH-1:0] param_data_q, param_data_d;
  logic                          param_load_q, param_load_d;
  logic                          done_q, done_d;
  logic                          vec_accept;
  logic                          load_entry;

  // Ready outputs depend on state only, never on the inputs.
  assign param_in_ready = (state_q == LOAD);
  assign vec_ready      = (state_q == FEED);
  assign busy           = (state_q != LOAD);
  assign vec_accept     = vec_valid && (state_q == FEED);
  assign load_entry     = (state_q != LOAD) && (state_d == LOAD);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    param_data_d = param_data_q;
    param_load_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (param_in_valid) begin
          param_data_d = param_in;
          param_load_d = 1'b1;
          if (beat_cnt_q == CNT_W'(ARRAY_N - 1)) begin
            beat_cnt_d = '0;
            state_d    = FEED;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      FEED: begin
        if (vec_accept && vec_last) begin
          flush_cnt_d = '0;
          state_d     = (ARRAY_N == 1) ? LOAD : FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == CNT_W'(ARRAY_N - 2)) begin
          flush_cnt_d = '0;
          state_d     = LOAD;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
    // The tail reaches the last lane in the first LOAD cycle after a batch.
    done_d = load_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      beat_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      param_data_q <= '0;
      param_load_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      param_data_q <= param_data_d;
      param_load_q <= param_load_d;
      done_q       <= done_d;
    end
  end

  assign param_data = param_data_q;
  assign param_load = param_load_q;
  assign done       = done_q;

`ifdef SYS_FEEDER_STATS_EN
  logic [15:0] vec_count_q, vec_count_d;

  always_comb begin
    vec_count_d = vec_count_q;
    if (load_entry) begin
      vec_count_d = '0;
    end else if (vec_accept && (vec_count_q != 16'hFFFF)) begin
      vec_count_d = vec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_count_q <= '0;
    end else begin
      vec_count_q <= vec_count_d;
    end
  end

  assign vec_count = vec_count_q;
`endif

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk       (clk),
      .reset     (reset),
      .in_data   (vec_accept ? vec_in[i*DATA_WIDTH +: DATA_WIDTH] : '0),
      .in_valid  (vec_accept),
      .out_data  (input_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (row_valid[i])
    );
  end

endmodule

// File: tb/tb_sys_array_feeder.sv
// tb/tb_sys_array_feeder.sv - directed self-checking bench for sys_array_feeder (ARRAY_N=4, DATA_WIDTH=8)
module tb_sys_array_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] param_in = '0;
  logic        param_in_valid = 1'b0;
  logic        param_in_ready;
  logic [31:0] vec_in = '0;
  logic        vec_valid = 1'b0;
  logic        vec_last = 1'b0;
  logic        vec_ready;
  logic [31:0] param_data;
  logic        param_load;
  logic [31:0] input_data;
  logic [3:0]  row_valid;
  logic        done;
  logic        busy;
`ifdef SYS_FEEDER_STATS_EN
  logic [15:0] vec_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_N(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .param_in       (param_in),
    .param_in_valid (param_in_valid),
    .param_in_ready (param_in_ready),
    .vec_in         (vec_in),
    .vec_valid      (vec_valid),
    .vec_last       (vec_last),
    .vec_ready      (vec_ready),
    .param_data     (param_data),
    .param_load     (param_load),
    .input_data     (input_data),
    .row_valid      (row_valid),
    .done           (done),
    .busy           (busy)
`ifdef SYS_FEEDER_STATS_EN
    ,
    .vec_count      (vec_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights_b2b();
    for (int k = 0; k < 4; k++) begin
      param_in       = {4{8'(k + 1)}};
      param_in_valid = 1'b1;
      tick();
      check_eq("w_load", 32'(param_load), 32'd1);
      check_eq("w_data", param_data, {4{8'(k + 1)}});
      check_eq("w_vec_ready", 32'(vec_ready), (k == 3) ? 32'd1 : 32'd0);
    end
    param_in_valid = 1'b0;
  endtask

  // Expected lane words/valids per cycle after acceptance, worked by hand.
  logic [31:0] skew_data [4] = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000};
  logic [3:0]  skew_rv   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] bub_data  [7] = '{32'h00000044, 32'h00003300, 32'h00220088, 32'h11007700,
                                 32'h00660000, 32'h55000000, 32'h00000000};
  logic [3:0]  bub_rv    [7] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};

  initial begin
    tick();
    tick();
    check_eq("rst_pin_ready", 32'(param_in_ready), 32'd1);
    check_eq("rst_vec_ready", 32'(vec_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_param_load", 32'(param_load), 32'd0);
    check_eq("rst_param_data", param_data, 32'd0);
    check_eq("rst_input_data", input_data, 32'd0);
    check_eq("rst_row_valid", 32'(row_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    load_weights_b2b();

    // param_in_valid during FEED must be ignored
    param_in       = 32'hDEADBEEF;
    param_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("feed_ign_load", 32'(param_load), 32'd0);
      check_eq("feed_ign_data", param_data, 32'h04040404);
      check_eq("feed_ign_rv", 32'(row_valid), 32'd0);
    end
    param_in_valid = 1'b0;

    // single-vector skew
    vec_in    = 32'h04030201;
    vec_valid = 1'b1;
    vec_last  = 1'b1;
    tick();
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check_eq($sformatf("skew_data%0d", k), input_data, skew_data[k]);
      check_eq($sformatf("skew_rv%0d", k), 32'(row_valid), 32'(skew_rv[k]));
      check_eq($sformatf("skew_done%0d", k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("skew_pready%0d", k), 32'(param_in_ready), (k == 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("skew_busy%0d", k), 32'(busy), (k == 3) ? 32'd0 : 32'd1);
    end
    tick();
    check_eq("skew_done_after", 32'(done), 32'd0);
    check_eq("skew_rv_after", 32'(row_valid), 32'd0);

    // gapped weight beats with vec_valid held high during LOAD
    vec_in    = 32'hA5A5A5A5;
    vec_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      param_in       = {4{8'(8'h10 + k)}};
      param_in_valid = 1'b1;
      tick();
      check_eq("gap_load_hi", 32'(param_load), 32'd1);
      check_eq("gap_data", param_data, {4{8'(8'h10 + k)}});
      check_eq("gap_rv", 32'(row_valid), 32'd0);
      check_eq("gap_vec_ready", 32'(vec_ready), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) begin
        param_in_valid = 1'b0;
        tick();
        check_eq("gap_load_lo", 32'(param_load), 32'd0);
        check_eq("gap_state_load", 32'(param_in_ready), 32'd1);
      end
    end
    vec_valid      = 1'b0;
    param_in_valid = 1'b0;
`ifdef SYS_FEEDER_STATS_EN
    check_eq("gap_vec_count", 32'(vec_count), 32'd0);
`endif

    // bubbles: V0, bubble, V1(last)
    for (int k = 0; k < 7; k++) begin
      vec_valid = (k == 0) || (k == 2);
      vec_last  = (k == 2);
      vec_in    = (k == 0) ? 32'h11223344 : (k == 2) ? 32'h55667788 : 32'h99999999;
      tick();
      check_eq($sformatf("bub_data%0d", k), input_data, bub_data[k]);
      check_eq($sformatf("bub_rv%0d", k), 32'(row_valid), 32'(bub_rv[k]));
      check_eq($sformatf("bub_done%0d", k), 32'(done), (k == 5) ? 32'd1 : 32'd0);
`ifdef SYS_FEEDER_STATS_EN
      if (k == 2) check_eq("bub_vec_count", 32'(vec_count), 32'd2);
      if (k == 5) check_eq("bub_vec_count_clr", 32'(vec_count), 32'd0);
`endif
      vec_valid = 1'b0;
      vec_last  = 1'b0;
    end

    // reset while data is in flight
    load_weights_b2b();
    vec_in    = 32'hAABBCCDD;
    vec_valid = 1'b1;
    tick();
    tick();
    check_eq("midfeed_nonzero", 32'(input_data != 0), 32'd1);
    vec_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_input_data", input_data, 32'd0);
    check_eq("mrst_row_valid", 32'(row_valid), 32'd0);
    check_eq("mrst_param_data", param_data, 32'd0);
    check_eq("mrst_param_load", 32'(param_load), 32'd0);
    check_eq("mrst_pin_ready", 32'(param_in_ready), 32'd1);
    check_eq("mrst_vec_ready", 32'(vec_ready), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("mrst_lane_data%0d", k), input_data, 32'd0);
      check_eq($sformatf("mrst_lane_rv%0d", k), 32'(row_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sys_array_feeder.md
# sys_array_feeder

Input-side driver for the weight-stationary systolic array: it is the transmitter that feeds the `sys_array_cell` grid. It loads one weight row per handshake beat into the array's parameter chain. It then accepts input vectors over a valid/ready handshake and emits them with the diagonal skew the array needs, so row `i` lags row 0 by `i` cycles. After the last vector it flushes zeros until the skewed tail has left, then returns to weight loading.

## Interface
- `DATA_WIDTH`, 8, element width (signed).
- `ARRAY_N`, 4, array dimension (rows = columns), ≥1.
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `param_in` in `ARRAY_N*DATA_WIDTH`: one weight row; column `j` is at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `param_in_valid` in 1: weight beat valid.
- `param_in_ready` out 1: feeder can accept a weight beat.
- `vec_in` in `ARRAY_N*DATA_WIDTH`: input vector; element `i` is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `vec_valid` in 1: vector valid.
- `vec_last` in 1: marks the final vector of a batch; qualified by the handshake.
- `vec_ready` out 1: feeder can accept a vector.
- `param_data` out `ARRAY_N*DATA_WIDTH`: weights to the top cell of each column.
- `param_load` out 1: weight shift strobe to the array.
- `input_data` out `ARRAY_N*DATA_WIDTH`: skewed data to the left cell of each row.
- `row_valid` out `ARRAY_N`: per-row valid, skewed the same way as `input_data`.
- `done` out 1: one-cycle batch-complete pulse.
- `busy` out 1: high in `FEED` or `FLUSH`.

## Operation
- **States:** `LOAD` (reset state), `FEED`, `FLUSH`.
- **`LOAD`:**
  - `param_in_ready`=1, `vec_ready`=0.
  - Each accepted beat (`param_in_valid && param_in_ready`) is registered to `param_data`, and `param_load`=1 for one cycle.
  - `param_load`=0 in cycles with no accepted beat; gaps are allowed.
  - Beat counter runs 0..`ARRAY_N-1`. After the `ARRAY_N`-th beat the state goes to `FEED`.
  - Beat 0 ends up in the bottom row, because the chain shifts downward.
- **`FEED`:**
  - `vec_ready`=1, `param_in_ready`=0.
  - An accepted vector pushes element `i` with valid=1 into lane `i`.
  - A cycle with no accepted vector pushes 0 with valid=0 (bubble).
  - An accepted vector with `vec_last`=1 moves the state to `FLUSH`, or straight to `LOAD` when `ARRAY_N`=1.
- **`FLUSH`:**
  - Both ready outputs are 0.
  - Lanes are pushed with 0/valid=0 for `ARRAY_N-1` cycles, then the state goes to `LOAD`.
- **Skew:** lane `i` is a delay line of `i+1` registers carrying data and valid. Lane 0 is a single register.
- **Ignored inputs:** `vec_valid` in `LOAD`/`FLUSH` and `param_in_valid` in `FEED`/`FLUSH` are ignored. There is no error flag.
- **Arithmetic:** no arithmetic; data passes through bit-exact. The beat counter and flush counter are `$clog2(ARRAY_N+1)` bits wide.

## Timing
- **Reset:**
  - Takes effect at the next edge in any state, including mid-batch.
  - State becomes `LOAD` and all counters clear.
  - All delay-line registers clear, so in-flight skewed data is discarded.
  - Every output is 0 except `param_in_ready`=1 (combinational from state).
- **Weight latency:** beat accepted at edge `t` → `param_data`/`param_load` valid in cycle `t+1`.
- **LOAD→FEED:** if the last beat is accepted at `t`, `vec_ready`=1 from cycle `t+1`. That is the same cycle as the last `param_load`.
- **Data latency:** vector accepted at `t` → `input_data` lane `i` and `row_valid[i]` at cycle `t+1+i`.
- **Batch end:** last vector accepted at `t` → the tail is on lane `ARRAY_N-1` at cycle `t+ARRAY_N`.
  - `done`=1 in exactly that cycle.
  - `param_in_ready`=1 from cycle `t+ARRAY_N`.
- **Ready signals:** both are functions of state only; no combinational path from inputs.

## Configuration
- **`SYS_FEEDER_STATS_EN` defined:**
  - Adds output `vec_count` (16 bits): number of vectors accepted in the current batch.
  - Clears on reset and on `LOAD` entry, saturates at 16'hFFFF, and holds its final value through `FLUSH` and until the next `LOAD` entry.
- **Not defined:** the port and its counter are absent. All other behaviour is identical.

## Structure
- **Package `sys_array_pkg`:** the `feeder_state_t` enum (`LOAD`, `FEED`, `FLUSH`) and the counter-width helper constant/function. Both are shared with the future output drain block.
- **Sub-module `skew_delay_line`:**
  - Parameters `DEPTH` and `DATA_WIDTH`; ports `clk`, `reset`, `in_data`, `in_valid`, `out_data`, `out_valid`.
  - Instantiated per lane in a generate loop with `DEPTH`=`i+1`.

## Test plan
All scenarios use `ARRAY_N`=4, `DATA_WIDTH`=8.
- **Reset mid-FEED:** assert `reset` while `input_data` is nonzero → next cycle all outputs are 0 and `param_in_ready`=1; lanes stay 0 for 4 further cycles.
- **Weight load:** 4 back-to-back beats 0x01010101, 0x02020202, 0x03030303, 0x04040404 → `param_load` high for 4 cycles with matching `param_data` one cycle late; `vec_ready` rises the cycle after the 4th beat.
- **Weight gaps:** beats with one idle cycle between each → `param_load` toggles 1,0,1,0…; state stays `LOAD` until 4 beats are accepted.
- **Skew:** single vector {4,3,2,1} (element 0 = 1) with `vec_last` at `t` →
  - lane 0 shows 1 at `t+1`, lane 1 shows 2 at `t+2`, lane 2 shows 3 at `t+3`, lane 3 shows 4 at `t+4`;
  - `done`=1 only at `t+4`.
- **Bubbles:** vectors V0, bubble, V1 (`vec_last`) → `row_valid[0]` pattern 1,0,1 and `row_valid[3]` the same pattern 3 cycles later; `input_data` is 0 in bubble slots.
- **Illegal inputs:** `vec_valid` held high during `LOAD` and `param_in_valid` held high during `FEED` → no vector pushed, no `param_load`, `vec_count`=0 (with `SYS_FEEDER_STATS_EN`).
